traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/tl_pkg.sv | 38 +++
 rtl/tl_tick_gen.sv | 33 +++
 rtl/traffic_light_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller: FSM state codes,
// lamp encodings, register-map offsets and power-on register values.
package tl_pkg;

  // FSM state codes; these are also what the phase output reports.
  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_WALK   = 2'd3
  } tl_state_e;

  // Per-approach lamp encoding (2 bits per approach).
  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  // Register addresses above the per-approach green block, relative to N_APPR.
  localparam int ADDR_OFF_YELLOW = 0;
  localparam int ADDR_OFF_ALLRED = 1;
  localparam int ADDR_OFF_WALK   = 2;

  // Power-on phase durations, in ticks.
  localparam int DEF_GREEN  = 5;
  localparam int DEF_YELLOW = 2;
  localparam int DEF_ALLRED = 1;
  localparam int DEF_WALK   = 4;

  // Round-robin helper: approach index base+offs wrapped into 0..n-1.
  // Both base and offs are below n, so one conditional subtract suffices.
  function automatic int wrap_appr(input int base, input int offs, input int n);
    int s;
    s = base + offs;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Free-running prescaler: emits a one-clock tick every PRESCALE cycles,
// counting from reset release (first tick after PRESCALE-1 rising edges).
module tl_tick_gen
  import tl_pkg::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic n_rst,
  output logic tick_o
);

  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap to zero after the last cycle of each period.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Prescaler counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic light controller with programmable phase times.
// Optional pedestrian walk phase is compiled in when TL_PED_EN is defined;
// the default build has no walk phase and ignores ped_req.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int N_APPR   = 2,
  parameter int TW       = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [N_APPR-1:0]   sensor,
  input  logic                wr_en,
  input  logic [2:0]          wr_addr,
  input  logic [TW-1:0]       wr_data,
  input  logic                ped_req,
  output logic [2*N_APPR-1:0] light,
  output logic                walk,
  output logic [1:0]          cur_appr,
  output logic [1:0]          phase
);

  localparam logic [2:0]    ADDR_YELLOW = 3'(N_APPR + ADDR_OFF_YELLOW);
  localparam logic [2:0]    ADDR_ALLRED = 3'(N_APPR + ADDR_OFF_ALLRED);
  localparam logic [TW-1:0] ONE         = TW'(1);

  // ---------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------
  logic tick;

  tl_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .n_rst  (n_rst),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------------
  // Demand synchroniser
  // ---------------------------------------------------------------------
  logic [N_APPR-1:0] sens_s1_q;
  logic [N_APPR-1:0] sens_s2_q;

  // Two-flop synchroniser for the asynchronous vehicle sensors.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sens_s1_q <= '0;
      sens_s2_q <= '0;
    end else begin
      sens_s1_q <= sensor;
      sens_s2_q <= sens_s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [TW-1:0]     green_q [N_APPR];
  logic [N_APPR-1:0] green_we;
  logic [TW-1:0]     yellow_q;
  logic [TW-1:0]     allred_q;
`ifdef TL_PED_EN
  localparam logic [2:0] ADDR_WALK = 3'(N_APPR + ADDR_OFF_WALK);
  logic [TW-1:0]     walk_t_q;
`endif

  // One write strobe per approach green-time register.
  for (genvar gi = 0; gi < N_APPR; gi++) begin : g_green_we
    assign green_we[gi] = wr_en && (wr_addr == 3'(gi));
  end

  // Phase-time registers: a write is visible on the following cycle, so an
  // expiry on the same edge as a write still loads the previous value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int j = 0; j < N_APPR; j++) green_q[j] <= TW'(DEF_GREEN);
      yellow_q <= TW'(DEF_YELLOW);
      allred_q <= TW'(DEF_ALLRED);
`ifdef TL_PED_EN
      walk_t_q <= TW'(DEF_WALK);
`endif
    end else begin
      for (int j = 0; j < N_APPR; j++) begin
        if (green_we[j]) green_q[j] <= wr_data;
      end
      if (wr_en && (wr_addr == ADDR_YELLOW)) yellow_q <= wr_data;
      if (wr_en && (wr_addr == ADDR_ALLRED)) allred_q <= wr_data;
`ifdef TL_PED_EN
      if (wr_en && (wr_addr == ADDR_WALK))   walk_t_q <= wr_data;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // FSM state, phase timer and registered outputs
  // ---------------------------------------------------------------------
  tl_state_e         state_q;
  logic [1:0]        cur_q;
  logic [1:0]        next_q;
  logic [TW-1:0]     timer_q;
  logic [2*N_APPR-1:0] light_q;
  logic              walk_q;
`ifdef TL_PED_EN
  logic              ped_q;
`else
  logic              unused_ped;
  assign unused_ped = ped_req;
`endif

  logic        expire;
  logic        rr_found;
  logic [1:0]  rr_pick;
  logic [1:0]  enter_appr;
  logic [TW-1:0] green_cur;
  logic [TW-1:0] green_enter;

  // The timer never holds zero (loads are clamped), so count==1 on a tick ends the phase.
  assign expire = tick && (timer_q <= ONE);

  // With no demand anywhere at all-red exit, green returns to approach 0.
  assign enter_appr = (|sens_s2_q) ? next_q : 2'd0;

  // Round-robin search for the first demanding approach after cur_appr.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = cur_q;
    for (int k = 1; k < N_APPR; k++) begin
      for (int j = 0; j < N_APPR; j++) begin
        if (!rr_found && sens_s2_q[j] &&
            (wrap_appr(int'(cur_q), k, N_APPR) == j)) begin
          rr_found = 1'b1;
          rr_pick  = 2'(j);
        end
      end
    end
  end

  // Green-time lookups for the current approach and the one about to enter.
  always_comb begin
    green_cur   = green_q[0];
    green_enter = green_q[0];
    for (int j = 0; j < N_APPR; j++) begin
      if (cur_q == 2'(j))      green_cur   = green_q[j];
      if (enter_appr == 2'(j)) green_enter = green_q[j];
    end
  end

  // A programmed duration of zero behaves as one tick.
  function automatic logic [TW-1:0] load_val(input logic [TW-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // Lamp vector with only approach appr showing code, all others red.
  function automatic logic [2*N_APPR-1:0] lights_for(input logic [1:0] appr,
                                                     input logic [1:0] code);
    logic [2*N_APPR-1:0] res;
    res = {N_APPR{LIGHT_RED}};
    for (int j = 0; j < N_APPR; j++) begin
      if (appr == 2'(j)) res[2*j +: 2] = code;
    end
    return res;
  endfunction

  // Phase sequencing: state, owning approach, stored next approach, timer and lamps.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_ALLRED;
      cur_q   <= 2'(N_APPR - 1);
      next_q  <= 2'd0;
      timer_q <= TW'(DEF_ALLRED);
      light_q <= '0;
      walk_q  <= 1'b0;
`ifdef TL_PED_EN
      ped_q   <= 1'b0;
`endif
    end else begin
`ifdef TL_PED_EN
      // Sticky pedestrian request; cleared below when the walk phase starts.
      if (ped_req) ped_q <= 1'b1;
`endif
      if (expire) begin
        case (state_q)
          ST_GREEN: begin
            if (rr_found) begin
              state_q <= ST_YELLOW;
              next_q  <= rr_pick;
              timer_q <= load_val(yellow_q);
              light_q <= lights_for(cur_q, LIGHT_YELLOW);
            end else begin
              timer_q <= load_val(green_cur);
            end
          end
          ST_YELLOW: begin
            state_q <= ST_ALLRED;
            timer_q <= load_val(allred_q);
            light_q <= '0;
          end
          ST_ALLRED: begin
`ifdef TL_PED_EN
            if (ped_q) begin
              state_q <= ST_WALK;
              timer_q <= load_val(walk_t_q);
              walk_q  <= 1'b1;
              ped_q   <= 1'b0;
            end else
`endif
            begin
              state_q <= ST_GREEN;
              cur_q   <= enter_appr;
              timer_q <= load_val(green_enter);
              light_q <= lights_for(enter_appr, LIGHT_GREEN);
            end
          end
          ST_WALK: begin
            state_q <= ST_ALLRED;
            timer_q <= load_val(allred_q);
            walk_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_ALLRED;
            timer_q <= load_val(allred_q);
            light_q <= '0;
            walk_q  <= 1'b0;
          end
        endcase
      end else if (tick) begin
        timer_q <= timer_q - ONE;
      end
    end
  end

  assign light    = light_q;
  assign walk     = walk_q;
  assign cur_appr = cur_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl (N_APPR=4, TW=4, PRESCALE=4).
// Directed table and hand-written sequences plus a randomized run checked
// every cycle against a tick-counting reference model.
module tb_traffic_light_ctrl;
  import tl_pkg::*;

  localparam int NA  = 4;
  localparam int TWB = 4;
  localparam int PRE = 4;
`ifdef TL_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic [NA-1:0]   sensor = '0;
  logic            wr_en = 1'b0;
  logic [2:0]      wr_addr = '0;
  logic [TWB-1:0]  wr_data = '0;
  logic            ped_req = 1'b0;
  logic [2*NA-1:0] light;
  logic            walk;
  logic [1:0]      cur_appr;
  logic [1:0]      phase;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.N_APPR(NA), .TW(TWB), .PRESCALE(PRE)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .sensor   (sensor),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ped_req  (ped_req),
    .light    (light),
    .walk     (walk),
    .cur_appr (cur_appr),
    .phase    (phase)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int         m_cyc;          // rising edges since reset release
  int         m_ph;           // phase code
  int         m_cur;
  int         m_nxt;
  int         m_dur;          // ticks the current phase lasts
  int         m_seen;         // ticks seen in the current phase
  logic [3:0] h0, h1;         // sensor one and two edges ago
  int         m_grn[NA];
  int         m_yel, m_ar, m_wk;
  bit         m_ped;

  function automatic int dur_of(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ph = int'(ST_ALLRED); m_cur = NA - 1; m_nxt = 0;
    m_dur = 1; m_seen = 0; h0 = '0; h1 = '0; m_ped = 1'b0;
    for (int i = 0; i < NA; i++) m_grn[i] = 5;
    m_yel = 2; m_ar = 1; m_wk = 4;
  endtask

  task automatic model_edge();
    logic [3:0] sync;
    bit tick, found;
    int a;
    sync = h1;
    tick = ((m_cyc % PRE) == PRE - 1);
    if (PED && ped_req) m_ped = 1'b1;
    if (tick) begin
      m_seen++;
      if (m_seen >= m_dur) begin
        m_seen = 0;
        if (m_ph == int'(ST_GREEN)) begin
          found = 1'b0;
          for (int k = 1; k < NA; k++) begin
            a = (m_cur + k) % NA;
            if (!found && sync[a]) begin found = 1'b1; m_nxt = a; end
          end
          if (found) begin m_ph = int'(ST_YELLOW); m_dur = dur_of(m_yel); end
          else m_dur = dur_of(m_grn[m_cur]);
        end else if (m_ph == int'(ST_YELLOW)) begin
          m_ph = int'(ST_ALLRED); m_dur = dur_of(m_ar);
        end else if (m_ph == int'(ST_ALLRED)) begin
          if (PED && m_ped) begin
            m_ph = int'(ST_WALK); m_dur = dur_of(m_wk); m_ped = 1'b0;
          end else begin
            m_cur = (sync == 0) ? 0 : m_nxt;
            m_ph  = int'(ST_GREEN); m_dur = dur_of(m_grn[m_cur]);
          end
        end else begin
          m_ph = int'(ST_ALLRED); m_dur = dur_of(m_ar);
        end
      end
    end
    if (wr_en) begin
      if (int'(wr_addr) < NA)              m_grn[wr_addr] = int'(wr_data);
      else if (int'(wr_addr) == NA)        m_yel = int'(wr_data);
      else if (int'(wr_addr) == NA + 1)    m_ar  = int'(wr_data);
      else if (int'(wr_addr) == NA + 2 && PED) m_wk = int'(wr_data);
    end
    h1 = h0;
    h0 = sensor;
    m_cyc++;
  endtask

  function automatic logic [12:0] model_out();
    logic [7:0] l;
    l = '0;
    if (m_ph == int'(ST_GREEN))       l[2*m_cur +: 2] = 2'b01;
    else if (m_ph == int'(ST_YELLOW)) l[2*m_cur +: 2] = 2'b10;
    return {l, 2'(m_ph), 2'(m_cur), (m_ph == int'(ST_WALK))};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (edge %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic chk_state(input string name, input logic [7:0] l, input logic [1:0] ph,
                           input logic [1:0] cu, input logic w);
    $display("%s edge=%0d light=%b phase=%0d cur=%0d walk=%b",
             name, m_cyc - 1, light, phase, cur_appr, walk);
    chk(name, 32'({light, phase, cur_appr, walk}), 32'({l, ph, cu, w}));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", 32'({light, phase, cur_appr, walk}), 32'(model_out()));
  endtask

  task automatic run_until(input int k);
    while (m_cyc <= k) step();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    wr_en = 1'b0; ped_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic wr_at(input int k, input int addr, input int data);
    run_until(k - 1);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 4'(data);
    step();
    wr_en = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] sens;
    int         upto;
    logic [7:0] light;
    logic [1:0] ph;
    logic [1:0] cur;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{4'b0000,  -1, 8'h00, ST_ALLRED, 2'd3};
    tbl[1]  = '{4'b0000,   2, 8'h00, ST_ALLRED, 2'd3};
    tbl[2]  = '{4'b0000,   3, 8'h01, ST_GREEN,  2'd0};
    tbl[3]  = '{4'b0000,  43, 8'h01, ST_GREEN,  2'd0};
    tbl[4]  = '{4'b0010,  62, 8'h01, ST_GREEN,  2'd0};
    tbl[5]  = '{4'b0010,  63, 8'h02, ST_YELLOW, 2'd0};
    tbl[6]  = '{4'b0010,  70, 8'h02, ST_YELLOW, 2'd0};
    tbl[7]  = '{4'b0010,  71, 8'h00, ST_ALLRED, 2'd0};
    tbl[8]  = '{4'b0010,  74, 8'h00, ST_ALLRED, 2'd0};
    tbl[9]  = '{4'b0010,  75, 8'h04, ST_GREEN,  2'd1};
    tbl[10] = '{4'b1010,  94, 8'h04, ST_GREEN,  2'd1};
    tbl[11] = '{4'b1010,  95, 8'h08, ST_YELLOW, 2'd1};
    tbl[12] = '{4'b1010, 107, 8'h40, ST_GREEN,  2'd3};

    // Sequence A: reset, idle green on approach 0, hand-over to 1, skip to 3.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      sensor = tbl[i].sens;
      run_until(tbl[i].upto);
      chk_state($sformatf("vec%0d", i), tbl[i].light, tbl[i].ph, tbl[i].cur, 1'b0);
    end

    // Sequence B: green[0]=2 written mid-green; running phase keeps 5 ticks.
    sensor = '0;
    do_reset();
    run_until(7);
    sensor = 4'b0100;
    wr_at(8, 0, 2);
    run_until(22); chk_state("wrB_g0_running", 8'h01, ST_GREEN, 2'd0, 1'b0);
    run_until(23); chk_state("wrB_g0_5ticks", 8'h02, ST_YELLOW, 2'd0, 1'b0);
    run_until(35); chk_state("wrB_g2", 8'h10, ST_GREEN, 2'd2, 1'b0);
    sensor = 4'b0001;
    run_until(67); chk_state("wrB_back_g0", 8'h01, ST_GREEN, 2'd0, 1'b0);
    sensor = 4'b0101;
    run_until(74); chk_state("wrB_g0_short", 8'h01, ST_GREEN, 2'd0, 1'b0);
    run_until(75); chk_state("wrB_g0_2ticks", 8'h02, ST_YELLOW, 2'd0, 1'b0);

    // Sequence C: asynchronous reset in the middle of yellow.
    sensor = 4'b0010;
    do_reset();
    run_until(25); chk_state("rstC_yellow", 8'h02, ST_YELLOW, 2'd0, 1'b0);
    #2 n_rst = 1'b0;
    #1 chk_state("rstC_async", 8'h00, ST_ALLRED, 2'd3, 1'b0);
    do_reset();
    run_until(2); chk_state("rstC_allred", 8'h00, ST_ALLRED, 2'd3, 1'b0);
    run_until(3); chk_state("rstC_green0", 8'h01, ST_GREEN, 2'd0, 1'b0);

    // Sequence D: pedestrian request during green.
    sensor = 4'b0010;
    do_reset();
    run_until(9);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run_until(34); chk_state("pedD_allred", 8'h00, ST_ALLRED, 2'd0, 1'b0);
    run_until(35);
    if (PED) chk_state("pedD_walk_start", 8'h00, ST_WALK, 2'd0, 1'b1);
    else     chk_state("pedD_no_walk", 8'h04, ST_GREEN, 2'd1, 1'b0);
    run_until(50);
    if (PED) chk_state("pedD_walk_end", 8'h00, ST_WALK, 2'd0, 1'b1);
    else     chk_state("pedD_green1", 8'h04, ST_GREEN, 2'd1, 1'b0);
    run_until(51);
    if (PED) chk_state("pedD_allred2", 8'h00, ST_ALLRED, 2'd0, 1'b0);
    else     chk_state("pedD_green1b", 8'h04, ST_GREEN, 2'd1, 1'b0);
    run_until(55); chk_state("pedD_green_after", 8'h04, ST_GREEN, 2'd1, 1'b0);

    // Randomized run against the model, with one reset in the middle.
    sensor = '0;
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        #2 do_reset();
      end
      if ($urandom_range(0, 7) == 0) sensor = 4'($urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 19) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 6));
      ped_req = ($urandom_range(0, 39) == 0);
      step();
    end
    wr_en = 1'b0; ped_req = 1'b0;
    $display("random run done, %0d edges since last reset", m_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
